// File: rtl/state_polytomsg_masked_decode.sv
// rtl/state_polytomsg_masked_decode.sv - first-order masked Kyber message-bit decoder, 3-cycle pipeline
module state_polytomsg_masked_decode #(
  parameter int KYBER_Q = 3329
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [15:0] c1,
  input  logic [15:0] c2,
  input  logic [15:0] PRNG_data,
  output logic        data_valid,
  output logic        m1,
  output logic        m2
);

  localparam logic [11:0] Q12 = 12'(KYBER_Q);
  localparam logic [12:0] Q13 = 13'(KYBER_Q);

  // Decision window for round(2v/q) mod 2: v in [q/4, 3q/4] decodes to 1.
  localparam logic [11:0] LO_BOUND = 12'd833;
  localparam logic [11:0] HI_BOUND = 12'd2496;

  // Upper coefficient bits and PRNG_data[14:12] carry no information here.
  logic unused_hi;
  assign unused_hi = ^{c1[15:12], c2[15:12], PRNG_data[14:12]};

  // Inputs are at most 4095 < 2q, so one conditional subtract fully reduces them.
  function automatic logic [11:0] red_q(input logic [11:0] x);
    return (x >= Q12) ? (x - Q12) : x;
  endfunction

  // Stage 1: reduced shares, reduced refresh mask r, Boolean mask bit
  logic [11:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic        mb1_q, mb1_d, v1_q, v1_d;
  // Stage 2: refreshed arithmetic shares
  logic [11:0] s1_q, s1_d, s2_q, s2_d;
  logic        mb2_q, mb2_d, v2_q, v2_d;
  // Stage 3: Boolean output shares
  logic        m1_q, m1_d, m2_q, m2_d, v3_q, v3_d;

  logic [12:0] sum_ar, sum_br, sum_s;
  logic [11:0] s1_new, s2_new, v_mod;
  logic        d_bit;

  // Stage 1: capture reduced inputs whenever ce is sampled high
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    r_d   = r_q;
    mb1_d = mb1_q;
    v1_d  = ce;
    if (ce) begin
      a_d   = red_q(c1[11:0]);
      b_d   = red_q(c2[11:0]);
      r_d   = red_q(PRNG_data[11:0]);
      mb1_d = PRNG_data[15];
    end
  end

  // Stage 2: re-randomise the sharing: s1 = a + r, s2 = b - r (mod q)
  always_comb begin
    sum_ar = {1'b0, a_q} + {1'b0, r_q};
    sum_br = {1'b0, b_q} + Q13 - {1'b0, r_q};
    s1_new = (sum_ar >= Q13) ? 12'(sum_ar - Q13) : sum_ar[11:0];
    s2_new = (sum_br >= Q13) ? 12'(sum_br - Q13) : sum_br[11:0];
    s1_d   = s1_q;
    s2_d   = s2_q;
    mb2_d  = mb2_q;
    v2_d   = v1_q;
    if (v1_q) begin
      s1_d  = s1_new;
      s2_d  = s2_new;
      mb2_d = mb1_q;
    end
  end

  // Stage 3: unmask into v only combinationally, then re-mask the decision bit with mb
  always_comb begin
    sum_s = {1'b0, s1_q} + {1'b0, s2_q};
    v_mod = (sum_s >= Q13) ? 12'(sum_s - Q13) : sum_s[11:0];
    d_bit = (v_mod >= LO_BOUND) && (v_mod <= HI_BOUND);
    m1_d  = m1_q;
    m2_d  = m2_q;
    v3_d  = v2_q;
    if (v2_q) begin
      m1_d = mb2_q;
      m2_d = d_bit ^ mb2_q;
    end
  end

  // Pipeline registers; reset drops every in-flight coefficient
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      mb1_q <= 1'b0;
      v1_q  <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
      mb2_q <= 1'b0;
      v2_q  <= 1'b0;
      m1_q  <= 1'b0;
      m2_q  <= 1'b0;
      v3_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      r_q   <= r_d;
      mb1_q <= mb1_d;
      v1_q  <= v1_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      mb2_q <= mb2_d;
      v2_q  <= v2_d;
      m1_q  <= m1_d;
      m2_q  <= m2_d;
      v3_q  <= v3_d;
    end
  end

  assign data_valid = v3_q;
  assign m1         = m1_q;
  assign m2         = m2_q;

endmodule

// File: tb/tb_state_polytomsg_masked_decode.sv
// tb/tb_state_polytomsg_masked_decode.sv - randomized self-checking bench for the masked decoder
module tb_state_polytomsg_masked_decode;

  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [15:0] c1, c2, prng;
  logic        data_valid, m1, m2;

  always #5 clk = ~clk;

  state_polytomsg_masked_decode dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .c1         (c1),
    .c2         (c2),
    .PRNG_data  (prng),
    .data_valid (data_valid),
    .m1         (m1),
    .m2         (m2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic        st_ce [0:299];
  logic [15:0] st_c1 [0:299];
  logic [15:0] st_c2 [0:299];
  logic [15:0] st_pr [0:299];
  logic        ob_dv [0:299];
  logic        ob_m1 [0:299];
  logic        ob_m2 [0:299];
  int          tail_dv;

  // Golden decode: round(2 * ((c1 + c2) mod q) / q) mod 2
  function automatic logic ref_bit(input logic [15:0] x, input logic [15:0] y);
    int a, b, v, r;
    a = int'(x[11:0]) % Q;
    b = int'(y[11:0]) % Q;
    v = (a + b) % Q;
    r = (4 * v + Q) / (2 * Q);
    return (r % 2) == 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives st_* for n cycles and records the output seen three cycles after each input cycle
  task automatic run_seq(input int n, input int tail_len);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        ce = st_ce[i]; c1 = st_c1[i]; c2 = st_c2[i]; prng = st_pr[i];
      end else begin
        ce = 1'b0; c1 = 16'($urandom); c2 = 16'($urandom); prng = 16'($urandom);
      end
      tick();
      if (i >= 2) begin
        ob_dv[i-2] = data_valid;
        ob_m1[i-2] = m1;
        ob_m2[i-2] = m2;
      end
    end
    ce = 1'b0;
    tail_dv = 0;
    for (int k = 0; k < tail_len; k++) begin
      tick();
      tail_dv += int'(data_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; c1 = 16'd1000; c2 = 16'd0; prng = 16'h8000;
    tick();
    tick();
    n_checks += 3;
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %b want 0", data_valid); end
    if (m1 !== 1'b0) begin n_fail++; $display("FAIL reset_m1 got %b want 0", m1); end
    if (m2 !== 1'b0) begin n_fail++; $display("FAIL reset_m2 got %b want 0", m2); end
    rst = 1'b0; ce = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ce_ignored cycle %0d got %b want 0", k, data_valid); end
    end
  endtask

  task automatic test_sweep();
    int   vals [7] = '{0, 832, 833, 1665, 2496, 2497, 3328};
    logic exp  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      st_ce[i] = 1'b1; st_c1[i] = 16'(vals[i]); st_c2[i] = 16'd0; st_pr[i] = 16'd0;
    end
    run_seq(7, 1);
    for (int j = 0; j < 7; j++) begin
      n_checks += 3;
      if (ob_dv[j] !== 1'b1) begin n_fail++; $display("FAIL sweep_dv c1=%0d got %b want 1", vals[j], ob_dv[j]); end
      if (ob_m1[j] !== 1'b0) begin n_fail++; $display("FAIL sweep_m1 c1=%0d got %b want 0", vals[j], ob_m1[j]); end
      if (ob_m2[j] !== exp[j]) begin n_fail++; $display("FAIL sweep_m2 c1=%0d got %b want %b", vals[j], ob_m2[j], exp[j]); end
    end
  endtask

  task automatic test_share_wrap();
    int wa [4] = '{3000, 2000, 1000, 2500};
    int wb [4] = '{329, 2000, 3000, 3329};
    for (int i = 0; i < 4; i++) begin
      st_ce[i] = 1'b1; st_c1[i] = 16'(wa[i]); st_c2[i] = 16'(wb[i]); st_pr[i] = 16'($urandom);
    end
    run_seq(4, 1);
    for (int j = 0; j < 4; j++) begin
      n_checks += 3;
      if (ob_dv[j] !== 1'b1) begin n_fail++; $display("FAIL wrap_dv case %0d got %b want 1", j, ob_dv[j]); end
      if (ob_m1[j] !== st_pr[j][15]) begin n_fail++; $display("FAIL wrap_m1 case %0d got %b want %b", j, ob_m1[j], st_pr[j][15]); end
      if ((ob_m1[j] ^ ob_m2[j]) !== 1'b0) begin n_fail++; $display("FAIL wrap_bit case %0d got %b want 0", j, ob_m1[j] ^ ob_m2[j]); end
    end
  endtask

  task automatic test_randomness();
    st_ce[0] = 1'b1; st_c1[0] = 16'd1665; st_c2[0] = 16'd0; st_pr[0] = 16'h0000;
    st_ce[1] = 1'b1; st_c1[1] = 16'd1665; st_c2[1] = 16'd0; st_pr[1] = 16'h8FFF;
    run_seq(2, 1);
    n_checks += 4;
    if (ob_m1[0] !== 1'b0) begin n_fail++; $display("FAIL rand0_m1 got %b want 0", ob_m1[0]); end
    if (ob_m2[0] !== 1'b1) begin n_fail++; $display("FAIL rand0_m2 got %b want 1", ob_m2[0]); end
    if (ob_m1[1] !== 1'b1) begin n_fail++; $display("FAIL rand1_m1 got %b want 1", ob_m1[1]); end
    if (ob_m2[1] !== 1'b0) begin n_fail++; $display("FAIL rand1_m2 got %b want 0", ob_m2[1]); end
  endtask

  task automatic test_stream();
    int dv_count = 0;
    for (int i = 0; i < 256; i++) begin
      st_ce[i] = 1'b1; st_c1[i] = 16'($urandom_range(4095)); st_c2[i] = 16'($urandom_range(4095));
      st_pr[i] = 16'($urandom);
    end
    run_seq(256, 6);
    for (int j = 0; j < 256; j++) begin
      dv_count += int'(ob_dv[j]);
      n_checks += 3;
      if (ob_dv[j] !== 1'b1) begin n_fail++; $display("FAIL stream_dv idx %0d got %b want 1", j, ob_dv[j]); end
      if (ob_m1[j] !== st_pr[j][15]) begin n_fail++; $display("FAIL stream_m1 idx %0d got %b want %b", j, ob_m1[j], st_pr[j][15]); end
      if ((ob_m1[j] ^ ob_m2[j]) !== ref_bit(st_c1[j], st_c2[j])) begin
        n_fail++;
        $display("FAIL stream_bit idx %0d c1=%0d c2=%0d got %b want %b", j, st_c1[j], st_c2[j], ob_m1[j] ^ ob_m2[j], ref_bit(st_c1[j], st_c2[j]));
      end
    end
    n_checks += 2;
    if (dv_count != 256) begin n_fail++; $display("FAIL stream_count got %0d want 256", dv_count); end
    if (tail_dv != 0) begin n_fail++; $display("FAIL stream_tail got %0d valid cycles want 0", tail_dv); end
  endtask

  task automatic test_ce_pattern();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_m1, exp_m2;
    exp_m1 = m1;
    exp_m2 = m2;
    for (int i = 0; i < 5; i++) begin
      st_ce[i] = pat[i]; st_c1[i] = 16'($urandom_range(4095)); st_c2[i] = 16'($urandom_range(4095));
      st_pr[i] = 16'($urandom);
    end
    run_seq(5, 2);
    for (int j = 0; j < 5; j++) begin
      if (pat[j]) begin
        exp_m1 = st_pr[j][15];
        exp_m2 = ref_bit(st_c1[j], st_c2[j]) ^ st_pr[j][15];
      end
      n_checks += 3;
      if (ob_dv[j] !== pat[j]) begin n_fail++; $display("FAIL pattern_dv idx %0d got %b want %b", j, ob_dv[j], pat[j]); end
      if (ob_m1[j] !== exp_m1) begin n_fail++; $display("FAIL pattern_m1 idx %0d got %b want %b", j, ob_m1[j], exp_m1); end
      if (ob_m2[j] !== exp_m2) begin n_fail++; $display("FAIL pattern_m2 idx %0d got %b want %b", j, ob_m2[j], exp_m2); end
    end
  endtask

  task automatic test_reset_midstream();
    int late_dv = 0;
    // Leave nonzero outputs behind so the reset clear is observable
    st_ce[0] = 1'b1; st_c1[0] = 16'd0; st_c2[0] = 16'd0; st_pr[0] = 16'h8000;
    run_seq(1, 1);
    n_checks += 2;
    if (m1 !== 1'b1) begin n_fail++; $display("FAIL prereset_m1 got %b want 1", m1); end
    if (m2 !== 1'b1) begin n_fail++; $display("FAIL prereset_m2 got %b want 1", m2); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ce = 1'b1; c1 = 16'($urandom_range(4095)); c2 = 16'($urandom_range(4095)); prng = 16'($urandom);
      rst = (i >= 2);
      tick();
      if (i == 2) begin
        n_checks += 3;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_dv got %b want 0", data_valid); end
        if (m1 !== 1'b0) begin n_fail++; $display("FAIL midrst_m1 got %b want 0", m1); end
        if (m2 !== 1'b0) begin n_fail++; $display("FAIL midrst_m2 got %b want 0", m2); end
      end
    end
    rst = 1'b0; ce = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      late_dv += int'(data_valid);
    end
    n_checks += 3;
    if (late_dv != 0) begin n_fail++; $display("FAIL midrst_stale got %0d valid cycles want 0", late_dv); end
    if (m1 !== 1'b0) begin n_fail++; $display("FAIL midrst_hold_m1 got %b want 0", m1); end
    if (m2 !== 1'b0) begin n_fail++; $display("FAIL midrst_hold_m2 got %b want 0", m2); end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; c1 = '0; c2 = '0; prng = '0;
    test_reset();
    test_sweep();
    test_share_wrap();
    test_randomness();
    test_stream();
    test_ce_pattern();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
